// File: rtl/ibex_xif_compressed_packer.sv
// RV32 -> RV32C compressor and little-endian parcel packer.
// Each accepted instruction becomes a 16- or 32-bit parcel; parcels are packed into 32-bit words.
module ibex_xif_compressed_packer #(
    parameter int unsigned CntWidth  = 32,
    parameter logic [15:0] PadParcel = 16'h0001
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                compress_en_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         in_instr_i,
    input  logic                flush_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [31:0]         out_data_o,
    output logic                idle_o,
    output logic [CntWidth-1:0] cnt_total_o,
    output logic [CntWidth-1:0] cnt_comp_o,
    output logic [CntWidth-1:0] cnt_illegal_o
);

    // Returns {is_compressed, parcel}; parcel is zero when no RVC form exists.
    function automatic logic [16:0] compress(input logic [31:0] instr);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm_i;
        logic [11:0] imm_s;
        logic        imm_i_fits6;
        logic        off_i_ok;
        logic        off_s_ok;
        logic [16:0] res;
        opc         = instr[6:0];
        f3          = instr[14:12];
        f7          = instr[31:25];
        rd          = instr[11:7];
        rs1         = instr[19:15];
        rs2         = instr[24:20];
        imm_i       = instr[31:20];
        imm_s       = {instr[31:25], instr[11:7]};
        imm_i_fits6 = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);
        // Word offsets 0..124 only: upper bits clear and 4-byte aligned.
        off_i_ok    = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'b00);
        off_s_ok    = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'b00);
        res         = '0;
        if (instr == 32'h0000_0013) begin
            res = {1'b1, 16'h0001};
        end else if (opc == 7'h13 && f3 == 3'b000 && rd == rs1 && rd != 5'd0 &&
                     imm_i != 12'd0 && imm_i_fits6) begin
            res = {1'b1, 3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (opc == 7'h13 && f3 == 3'b000 && rs1 == 5'd0 && rd != 5'd0 &&
                     imm_i_fits6) begin
            res = {1'b1, 3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (opc == 7'h33 && f3 == 3'b000 && f7 == 7'd0 && rs1 == 5'd0 &&
                     rd != 5'd0 && rs2 != 5'd0) begin
            res = {1'b1, 4'b1000, rd, rs2, 2'b10};
        end else if (opc == 7'h33 && f3 == 3'b000 && f7 == 7'd0 && rd == rs1 &&
                     rd != 5'd0 && rs2 != 5'd0) begin
            res = {1'b1, 4'b1001, rd, rs2, 2'b10};
        end else if (opc == 7'h67 && f3 == 3'b000 && rd == 5'd0 && imm_i == 12'd0 &&
                     rs1 != 5'd0) begin
            res = {1'b1, 4'b1000, rs1, 5'd0, 2'b10};
        end else if (instr == 32'h0010_0073) begin
            res = {1'b1, 16'h9002};
        end else if (opc == 7'h03 && f3 == 3'b010 && rd[4:3] == 2'b01 &&
                     rs1[4:3] == 2'b01 && off_i_ok) begin
            res = {1'b1, 3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end else if (opc == 7'h23 && f3 == 3'b010 && rs2[4:3] == 2'b01 &&
                     rs1[4:3] == 2'b01 && off_s_ok) begin
            res = {1'b1, 3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        end
        return res;
    endfunction

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (&v) ? v : v + CntWidth'(1);
    endfunction

    logic                r_out_valid;
    logic [31:0]         r_out_data;
    logic                r_pend_valid;
    logic [15:0]         r_pend;
    logic [CntWidth-1:0] r_cnt_total;
    logic [CntWidth-1:0] r_cnt_comp;
    logic [CntWidth-1:0] r_cnt_illegal;

    logic        w_accept;
    logic        w_flush;
    logic        w_illegal;
    logic [16:0] w_comp;
    logic        w_is16;
    logic [15:0] w_parcel;
    logic        w_out_valid_d;
    logic [31:0] w_out_data_d;
    logic        w_pend_valid_d;
    logic [15:0] w_pend_d;

    assign in_ready_o = !r_out_valid || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_flush    = flush_i && r_pend_valid && in_ready_o && !in_valid_i;
    assign w_illegal  = (in_instr_i[1:0] != 2'b11);
    assign w_comp     = (compress_en_i && !w_illegal) ? compress(in_instr_i) : 17'd0;
    assign w_is16     = w_comp[16];
    assign w_parcel   = w_comp[15:0];

    always_comb begin
        w_out_valid_d  = r_out_valid;
        w_out_data_d   = r_out_data;
        w_pend_valid_d = r_pend_valid;
        w_pend_d       = r_pend;
        if (r_out_valid && out_ready_i) begin
            w_out_valid_d = 1'b0;
        end
        if (w_accept) begin
            if (!r_pend_valid) begin
                if (w_is16) begin
                    w_pend_d       = w_parcel;
                    w_pend_valid_d = 1'b1;
                end else begin
                    w_out_data_d  = in_instr_i;
                    w_out_valid_d = 1'b1;
                end
            end else if (w_is16) begin
                w_out_data_d   = {w_parcel, r_pend};
                w_out_valid_d  = 1'b1;
                w_pend_valid_d = 1'b0;
            end else begin
                // Low half completes the pending word; high half becomes the new pending parcel.
                w_out_data_d  = {in_instr_i[15:0], r_pend};
                w_out_valid_d = 1'b1;
                w_pend_d      = in_instr_i[31:16];
            end
        end else if (w_flush) begin
            w_out_data_d   = {PadParcel, r_pend};
            w_out_valid_d  = 1'b1;
            w_pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= 32'd0;
            r_pend_valid  <= 1'b0;
            r_pend        <= 16'd0;
            r_cnt_total   <= '0;
            r_cnt_comp    <= '0;
            r_cnt_illegal <= '0;
        end else begin
            r_out_valid  <= w_out_valid_d;
            r_out_data   <= w_out_data_d;
            r_pend_valid <= w_pend_valid_d;
            r_pend       <= w_pend_d;
            if (w_accept) begin
                r_cnt_total <= sat_inc(r_cnt_total);
                if (w_is16) begin
                    r_cnt_comp <= sat_inc(r_cnt_comp);
                end
                if (w_illegal) begin
                    r_cnt_illegal <= sat_inc(r_cnt_illegal);
                end
            end
        end
    end

    assign out_valid_o   = r_out_valid;
    assign out_data_o    = r_out_data;
    assign idle_o        = !r_pend_valid && !r_out_valid;
    assign cnt_total_o   = r_cnt_total;
    assign cnt_comp_o    = r_cnt_comp;
    assign cnt_illegal_o = r_cnt_illegal;

endmodule

// File: doc/ibex_xif_compressed_packer.md
Name: ibex_xif_compressed_packer

Overview:
Streaming RV32 -> RV32C compressor and parcel packer, the inverse of the core's compressed decoder. It accepts one 32-bit RV32I instruction per handshake and substitutes the 16-bit RVC form when the instruction has an exact compressed equivalent in the supported subset. It packs the resulting 16/32-bit parcels little-endian into 32-bit output words. It sits between the XIF offload/test image generator and instruction memory or fetch stimulus.

Parameters:
CntWidth, 32, width of the saturating statistics counters
PadParcel, 16'h0001, halfword used to pad a flushed word (c.nop)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
compress_en_i  in  1  1: substitute RVC forms; 0: pass all instructions through as 32-bit
in_valid_i  in  1  input instruction valid
in_ready_o  out  1  input accepted when in_valid_i && in_ready_o
in_instr_i  in  32  RV32 instruction
flush_i  in  1  level; request emission of a pending halfword
out_valid_o  out  1  output word valid
out_ready_i  in  1  output consumer ready
out_data_o  out  32  packed word; [15:0] is the earlier parcel
idle_o  out  1  no pending halfword and no held output word
cnt_total_o  out  CntWidth  instructions accepted
cnt_comp_o  out  CntWidth  instructions emitted as 16-bit
cnt_illegal_o  out  CntWidth  accepted words with [1:0] != 2'b11

Behaviour:
- Clock and reset: one clock, clk_i. Reset is rst_ni, asynchronous, active-low.
- Reset state: out_valid_o=0, out_data_o=0, pending empty, all counters 0, idle_o=1.
- State: output register (out_valid_q, out_data_q) and pending register (pend_valid_q, pend_q[15:0]).
- in_ready_o = !out_valid_q || out_ready_i. Purely combinational from state and out_ready_i; in_valid_i never feeds it.
- Output handshake: the word is consumed when out_valid_o && out_ready_i. out_data_o stays stable while out_valid_o=1 && !out_ready_i.
- Compression subset. First match wins. Only applies when compress_en_i=1 and in_instr_i[1:0]=2'b11.
  - c.nop = 0x0001: ADDI x0,x0,0.
  - c.addi: ADDI, rd==rs1, rd!=0, imm!=0, imm in [-32,31] -> {3'b000, imm[5], rd, imm[4:0], 2'b01}.
  - c.li: ADDI, rs1==0, rd!=0, imm in [-32,31] -> {3'b010, imm[5], rd, imm[4:0], 2'b01}.
  - c.mv: ADD (funct7=0), rs1==0, rd!=0, rs2!=0 -> {4'b1000, rd, rs2, 2'b10}.
  - c.add: ADD, rd==rs1, rd!=0, rs2!=0 -> {4'b1001, rd, rs2, 2'b10}.
  - c.jr: JALR, rd==0, imm==0, rs1!=0 -> {4'b1000, rs1, 5'b0, 2'b10}.
  - c.ebreak: 0x00100073 -> 0x9002.
  - c.lw: LW, rd and rs1 in x8..x15, offset in [0,124], offset[1:0]=0 -> {3'b010, off[5:3], rs1[2:0], off[2], off[6], rd[2:0], 2'b00}.
  - c.sw: SW, rs2 and rs1 in x8..x15, same offset rule -> {3'b110, off[5:3], rs1[2:0], off[2], off[6], rs2[2:0], 2'b00}.
  - Everything else is emitted unchanged as 32 bits.
- Words with [1:0]!=2'b11 are emitted unchanged as 32 bits and increment cnt_illegal.
- On accept, with c = the 16-bit parcel:
  - pend empty, 16-bit: pend_q<=c, pend_valid<=1, no output.
  - pend empty, 32-bit: out_data<=instr, out_valid<=1.
  - pend full, 16-bit: out_data<={c, pend_q}, out_valid<=1, pend cleared.
  - pend full, 32-bit: out_data<={instr[15:0], pend_q}, out_valid<=1, pend_q<=instr[31:16].
- Timing: the output word appears the cycle after the accept. This gives one cycle of latency and full throughput when out_ready_i=1.
- Flush: acts only when flush_i && pend_valid_q && in_ready_o && !in_valid_i. It sets out_data<={PadParcel, pend_q}, out_valid<=1 and clears pend.
  - An accepted instruction takes priority over flush; flush_i must stay high until idle_o.
  - flush_i with pend empty does nothing.
- idle_o = !pend_valid_q && !out_valid_q.
- Counters: increment on accept and saturate at all-ones, never wrapping. cnt_comp counts 16-bit emissions.
- compress_en_i is sampled at accept only; toggling it does not disturb the pending halfword.
- Reset asserted mid-stream discards the pending halfword and the held word.

Test Plan:
- ADDI x8,x8,5 (0x00540413) then ADD x9,x9,x10 (0x00A484B3), out_ready=1 -> single word 0x94AA0415 one cycle after the second accept; cnt_total=2, cnt_comp=2.
- LW x9,8(x10) (0x00852483) then ADDI x0,x0,0 (0x00000013) -> 0x00014504. Also LW x9,128(x10) -> emitted as 32-bit 0x08052483.
- ADDI x0,x0,0 then LUI x5,0x12345 (0x123452B7) -> 0x52B70001 with pend 0x1234. Then flush_i=1 with in_valid=0 -> 0x00011234, after which idle_o=1.
- Backpressure: out_ready=0 with a word held -> in_ready_o=0 and out_data stable for 10 cycles. On release, the word is consumed and in_ready_o returns to 1 in the same cycle.
- compress_en_i=0 with ADD x9,x9,x10 -> 0x00A484B3 unchanged, cnt_comp unchanged. Input 0x00000415 -> passed through unchanged, cnt_illegal=1.
- Assert rst_ni low asynchronously while a halfword is pending and a word is held -> out_valid_o=0, idle_o=1, counters 0 immediately. After release, the next 32-bit input is emitted alone with no stale halfword.
